// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   arb_state_e  : FSM encoding (idle = 0, grant = 1, turnaround = 2)
//   DefMaxTenure : default grant tenure limit, in cycles
//   idx_width()  : minimum bit width needed to index n items
package bus_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StTurn  = 2'd2
  } arb_state_e;

  localparam int unsigned DefMaxTenure = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector, bit i belongs to requester i
//   ptr   : requester with highest priority this round (must be < N)
//   valid : any request is set
//   pick  : first set request at or above ptr, wrapping modulo N
module rr_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] pick
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    // Low half holds requests at/above ptr, high half the full vector for the wrap-around.
    dbl   = {req, req & mask};
    valid = |req;
    pick  = '0;
    // Scan downward so the lowest set position in the doubled vector wins.
    for (int j = 2 * N - 1; j >= 0; j--) begin
      if (dbl[j]) begin
        pick = (j >= int'(N)) ? IDX_W'(j - int'(N)) : IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master round-robin arbiter for the shared system bus.
// Registered grants, fair rotation, bounded tenure with preemption, and a
// mandatory one-cycle dead turnaround between owners.
//   clk     : system clock
//   bReset  : synchronous active-low reset
//   Breq    : request per master
//   Block   : (ARB_LOCK_EN only) suppress tenure preemption of the current owner
//   Bgnt    : registered one-hot-or-zero grant
//   Bbusy   : registered OR of Bgnt
//   Owner   : index of the current/last grantee
//   Preempt : one-cycle pulse when a grant is revoked by tenure expiry
// Optional feature macro: ARB_LOCK_EN (adds the Block input).
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned MAX_TENURE  = DefMaxTenure,
  parameter int unsigned IDX_W       = 2
) (
  input  logic                   clk,
  input  logic                   bReset,
  input  logic [NUM_MASTERS-1:0] Breq,
`ifdef ARB_LOCK_EN
  input  logic                   Block,
`endif
  output logic [NUM_MASTERS-1:0] Bgnt,
  output logic                   Bbusy,
  output logic [IDX_W-1:0]       Owner,
  output logic                   Preempt
);

  // Counter holds 0..MAX_TENURE and saturates there.
  localparam int unsigned TenW = idx_width(MAX_TENURE + 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] bgnt_q, bgnt_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [TenW-1:0]        tenure_q, tenure_d;
  logic                   preempt_q, preempt_d;
  logic                   busy_q;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             lock_hold;
  logic             owner_req;
  logic             others_req;
  logic             expired;

  rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (Breq),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .pick  (pick_idx)
  );

`ifdef ARB_LOCK_EN
  assign lock_hold = Block;
`else
  assign lock_hold = 1'b0;
`endif

  assign owner_req  = Breq[owner_q];
  assign others_req = |(Breq & ~bgnt_q);
  assign expired    = (tenure_q >= TenW'(MAX_TENURE));

  always_comb begin
    state_d   = state_q;
    bgnt_d    = bgnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    tenure_d  = tenure_q;
    preempt_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          bgnt_d           = '0;
          bgnt_d[pick_idx] = 1'b1;
          owner_d          = pick_idx;
          tenure_d         = TenW'(1);
          state_d          = StGrant;
          ptr_d            = (pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      StGrant: begin
        if (!owner_req) begin
          // A release wins over a simultaneous expiry, so no preempt pulse here.
          bgnt_d  = '0;
          state_d = StTurn;
        end else if (expired && others_req && !lock_hold) begin
          bgnt_d    = '0;
          preempt_d = 1'b1;
          state_d   = StTurn;
        end else if (!expired) begin
          tenure_d = tenure_q + 1'b1;
        end
      end
      StTurn: begin
        state_d = StIdle;
      end
      default: begin
        bgnt_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!bReset) begin
      state_q   <= StIdle;
      bgnt_q    <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      tenure_q  <= '0;
      preempt_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bgnt_q    <= bgnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      tenure_q  <= tenure_d;
      preempt_q <= preempt_d;
      busy_q    <= |bgnt_d;
    end
  end

  assign Bgnt    = bgnt_q;
  assign Bbusy   = busy_q;
  assign Owner   = owner_q;
  assign Preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus random requests, every
// cycle compared against a rule-level reference model.
module tb_bus_arbiter_rr;

  localparam int N    = 3;
  localparam int MAXT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         block;
  logic [N-1:0] bgnt;
  logic         busy;
  logic [1:0]   owner;
  logic         preempt;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit m_granted, m_dead, m_pre;
  int m_owner, m_ptr, m_held;

  always #5 clk = ~clk;

  bus_arbiter_rr #(
    .NUM_MASTERS (N),
    .MAX_TENURE  (MAXT),
    .IDX_W       (2)
  ) dut (
    .clk     (clk),
    .bReset  (rst_n),
    .Breq    (req),
`ifdef ARB_LOCK_EN
    .Block   (block),
`endif
    .Bgnt    (bgnt),
    .Bbusy   (busy),
    .Owner   (owner),
    .Preempt (preempt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the arbitration rules, applied to the inputs present at the edge.
  task automatic model_step();
    bit lk;
    bit others;
`ifdef ARB_LOCK_EN
    lk = block;
`else
    lk = 1'b0;
`endif
    if (!rst_n) begin
      m_granted = 0; m_dead = 0; m_pre = 0;
      m_owner = 0; m_ptr = 0; m_held = 0;
    end else if (m_granted) begin
      m_pre  = 0;
      others = 0;
      for (int i = 0; i < N; i++) if (i != m_owner && req[i]) others = 1;
      if (!req[m_owner]) begin
        m_granted = 0; m_dead = 1;
      end else if (m_held >= MAXT && others && !lk) begin
        m_granted = 0; m_dead = 1; m_pre = 1;
      end else if (m_held < MAXT) begin
        m_held++;
      end
    end else if (m_dead) begin
      m_dead = 0; m_pre = 0;
    end else begin
      m_pre = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (!m_granted && req[i]) begin
          m_granted = 1; m_owner = i; m_held = 1; m_ptr = (i + 1) % N;
        end
      end
    end
  endtask

  task automatic step();
    int exp_g;
    @(posedge clk);
    model_step();
    #1;
    exp_g = m_granted ? (1 << m_owner) : 0;
    check("bgnt", 32'(bgnt), 32'(exp_g));
    check("busy", 32'(busy), 32'(m_granted));
    check("owner", 32'(owner), 32'(m_owner));
    check("preempt", 32'(preempt), 32'(m_pre));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int gaps[$];
    int zeros;
    int held;
    int bad;
    bit prev_g;
    logic [2:0] exp_order [4];

    rst_n = 1'b0; req = 3'b111; block = 1'b0;

    // Reset with all requesting
    cyc(2);
    check("rst_bgnt", 32'(bgnt), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);

    // First grant one cycle after the request
    rst_n = 1'b1; req = 3'b010;
    step();
    check("single_bgnt", 32'(bgnt), 32'b010);
    check("single_busy", 32'(busy), 32'd1);
    req = 3'b000;
    cyc(3);

    // Fair rotation: every master drops after two granted cycles
    rst_n = 1'b0; step();
    rst_n = 1'b1; req = 3'b111;
    zeros = 0; held = 0; prev_g = 0;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      step();
      if (bgnt != 0) begin
        if (!prev_g) begin
          order.push_back(int'(owner));
          if (order.size() > 1) gaps.push_back(zeros);
          zeros = 0; held = 0;
        end
        held++;
        prev_g = 1;
        if (held == 2) req = 3'b111 & ~bgnt;
      end else begin
        prev_g = 0;
        zeros++;
        req = 3'b111;
      end
    end
    exp_order[0] = 3'd0; exp_order[1] = 3'd1; exp_order[2] = 3'd2; exp_order[3] = 3'd0;
    check("rot_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size() && i < 4; i++) check("rot_order", 32'(order[i]), 32'(exp_order[i]));
    foreach (gaps[i]) check("rot_gap", 32'(gaps[i]), 32'd2);
    req = 3'b000;
    cyc(3);

    // Tenure preemption
    rst_n = 1'b0; step();
    rst_n = 1'b1; req = 3'b001;
    step();
    check("ten_grant0", 32'(bgnt), 32'b001);
    step();
    req = 3'b101;
    cyc(3);
    check("ten_preempt", 32'(preempt), 32'd1);
    check("ten_drop", 32'(bgnt), 32'd0);
    cyc(2);
    check("ten_grant2", 32'(bgnt), 32'b100);
    req = 3'b000;
    cyc(3);

    // Lone holder keeps the bus
    req = 3'b010;
    step();
    check("lone_grant", 32'(bgnt), 32'b010);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bgnt !== 3'b010 || preempt !== 1'b0) bad++;
    end
    check("lone_hold", 32'(bad), 32'd0);

    // Reset in the middle of a grant
    req = 3'b100;
    for (int i = 0; i < 8 && bgnt !== 3'b100; i++) step();
    check("mid_setup", 32'(bgnt), 32'b100);
    rst_n = 1'b0;
    step();
    check("mid_bgnt", 32'(bgnt), 32'd0);
    check("mid_owner", 32'(owner), 32'd0);
    rst_n = 1'b1; req = 3'b100;
    step();
    check("mid_regrant", 32'(bgnt), 32'b100);
    req = 3'b000;
    cyc(3);

`ifdef ARB_LOCK_EN
    // Locked owner is not preempted until the lock drops
    rst_n = 1'b0; step();
    rst_n = 1'b1; req = 3'b001; block = 1'b1;
    step();
    req = 3'b011;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (preempt !== 1'b0 || bgnt !== 3'b001) bad++;
    end
    check("lock_hold", 32'(bad), 32'd0);
    block = 1'b0;
    step();
    check("lock_preempt", 32'(preempt), 32'd1);
    cyc(2);
    check("lock_next", 32'(bgnt), 32'b010);
    req = 3'b000;
    cyc(3);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 7) == 0) block = ~block;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised N-master round-robin arbiter for the shared DataBus/AddressBus/ControlBus system bus.
- Successor to the fixed 3-way combinational arbiter.
- Adds:
  - registered grants;
  - fair rotation;
  - a bounded ownership tenure with preemption;
  - a mandatory one-cycle turnaround between owners, to avoid inout bus contention.
- Sits between the bus wrappers (SRAM, UART, external master) and the bus; one Breq/Bgnt pair per wrapper.

Parameters:
- NUM_MASTERS, 3: number of requesters (2..16).
- MAX_TENURE, 16: maximum consecutive grant cycles before preemption when others are waiting (1..255).
- IDX_W, 2: width of the owner index; must be at least clog2(NUM_MASTERS).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- bReset  input  1  synchronous, active-low reset.
- Breq  input  NUM_MASTERS  request per master; bit i belongs to master i.
- Bgnt  output  NUM_MASTERS  registered one-hot-or-zero grant.
- Bbusy  output  1  high while any Bgnt bit is high.
- Owner  output  IDX_W  index of the current grantee; holds the last owner when idle.
- Preempt  output  1  one-cycle pulse when a grant is revoked by tenure expiry.

Behaviour:
- Clock and reset: one clock, clk. Reset bReset is synchronous and active-low: sampled only on the rising edge of clk while low.
- Reset values: Bgnt=0, Bbusy=0, Owner=0, Preempt=0, state=IDLE, rr pointer=0, tenure counter=0.
- States:
  - IDLE: no grant.
  - GRANT: exactly one Bgnt bit high.
  - TURN: one dead cycle, all Bgnt=0.
- IDLE:
  - If Breq is nonzero, pick the first set bit scanning from the rr pointer upward, wrapping modulo NUM_MASTERS.
  - Next cycle: Bgnt[pick]=1, Owner=pick, tenure=1, state=GRANT, pointer=(pick+1) mod NUM_MASTERS.
  - Latency: request sampled in cycle t produces a grant visible in cycle t+1.
- GRANT, each cycle:
  - Breq[Owner]=0: next cycle Bgnt=0, state=TURN.
  - Otherwise, if tenure >= MAX_TENURE and another Breq bit is set: next cycle Bgnt=0, Preempt=1 for one cycle, state=TURN.
  - Otherwise: hold the grant; tenure increments, saturating at MAX_TENURE.
  - A lone requester keeps the bus indefinitely.
- TURN: always goes to IDLE next cycle. Requests are not evaluated in TURN. The minimum gap between two grants is therefore 2 cycles with Bgnt all zero.
- Requests from non-owners that change during GRANT have no effect until IDLE.
- Breq bits at index >= NUM_MASTERS do not exist. Owner never exceeds NUM_MASTERS-1.
- Simultaneous drop of the owner's request and tenure expiry: treated as a normal release, with Preempt=0.
- Reset asserted mid-GRANT: the grant drops on the next edge. There is no TURN cycle; reset values apply.
- Bbusy is the registered OR of Bgnt, aligned with Bgnt.

Optional Feature:
- Macro: ARB_LOCK_EN.
- When defined:
  - Adds input Block (1 bit).
  - While in GRANT with Block=1 and Breq[Owner]=1, tenure-expiry preemption is suppressed. Used for atomic read-modify-write through the SRAM wrapper.
  - Block is ignored outside GRANT.
  - Block dropping while tenure >= MAX_TENURE and others are waiting causes preemption on the next edge.
- When not defined: no Block port; tenure preemption is always active.

Decomposition:
- Shared package bus_arb_pkg:
  - state encoding constants: IDLE=2'd0, GRANT=2'd1, TURN=2'd2;
  - default MAX_TENURE;
  - an index-width helper function.
- Sub-module rr_pick, combinational:
  - inputs: request vector and pointer;
  - outputs: valid flag and picked index;
  - implementation: rotate-mask with a double-width priority scan.
- Top module holds the FSM, tenure counter, pointer and output registers.

Test Plan:
- Reset and single request:
  - Hold bReset=0 for 2 cycles with Breq=3'b111 → Bgnt=0, Owner=0.
  - Release reset with Breq=3'b010 → Bgnt=3'b010 one cycle later, Bbusy=1.
- Fair rotation:
  - Breq=3'b111 held, each master releasing after 2 granted cycles → grant order 0,1,2,0, each grant separated by exactly 2 cycles of Bgnt=0.
- Tenure preemption:
  - MAX_TENURE=4; master 0 holds Breq, master 2 requests at grant cycle 2 → Bgnt[0] drops after its 4th cycle with Preempt pulse=1.
  - Bgnt=3'b100 two cycles later.
- Lone holder:
  - Only Breq[1]=1 for 40 cycles → Bgnt=3'b010 continuous, Preempt never asserted.
- Reset mid-grant:
  - bReset=0 during GRANT of master 2 → Bgnt=0 and Owner=0 on the next edge.
  - After release with Breq=3'b100 → grant to master 2.
- ARB_LOCK_EN:
  - MAX_TENURE=4, master 0 holds Block=1 for 10 cycles while master 1 waits → no preemption.
  - Block drops → Preempt=1 next edge, then Bgnt=3'b010 two cycles later.
